// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared register map, ap_ctrl bit positions and FSM states for fir_ctrl
package fir_pkg;

  localparam int ADDR_CTRL = 'h00;
  localparam int ADDR_LEN  = 'h10;
  localparam int ADDR_TAP  = 'h20;

  localparam int BIT_START = 0;
  localparam int BIT_DONE  = 1;
  localparam int BIT_IDLE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - AXI-Lite register front end, tap RAM arbiter and run/done FSM for the FIR engine
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   ap_start,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic                   eng_tap_en,
  input  logic [3:0]             eng_tap_idx,
  input  logic                   eng_done
);

  localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(ADDR_CTRL);
  localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(ADDR_LEN);
  localparam logic [pADDR_WIDTH-1:0] A_TAP     = pADDR_WIDTH'(ADDR_TAP);
  localparam logic [pADDR_WIDTH-1:0] A_TAP_END = pADDR_WIDTH'(ADDR_TAP + 4 * Tape_Num);

  fir_state_e state, state_nx;

  logic                   wr_grant, wr_is_tap, start_wr;
  logic                   tap_wr_pend;
  logic [pADDR_WIDTH-1:0] tap_wr_a;
  logic [pDATA_WIDTH-1:0] tap_wr_d;

  logic                   rd_busy, rd_s1, rd_first, rd_tap_live, rvalid_q;
  logic [pADDR_WIDTH-1:0] rd_addr;
  logic                   rd_is_tap, rd_ret;
  logic [pDATA_WIDTH-1:0] rd_val, rdata_q;

  assign wr_grant  = awvalid && wvalid && axis_rst_n;
  assign awready   = wr_grant;
  assign wready    = wr_grant;
  assign wr_is_tap = (awaddr >= A_TAP) && (awaddr < A_TAP_END);
  assign start_wr  = wr_grant && (awaddr == A_CTRL) && wdata[BIT_START] && (state != ST_RUN);

  // A granted write always beats a pending read request in the same cycle.
  assign arready   = arvalid && !rd_busy && !wr_grant && axis_rst_n;
  assign rd_is_tap = (rd_addr >= A_TAP) && (rd_addr < A_TAP_END);
  assign rd_ret    = rvalid_q && rready;
  assign rvalid    = rvalid_q;
  assign rdata     = (rd_first && rd_tap_live) ? tap_Do : rdata_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_wr) state_nx = ST_RUN;
      ST_RUN:  if (eng_done) state_nx = ST_DONE;
      ST_DONE: begin
        if (start_wr)                          state_nx = ST_RUN;
        else if (rd_ret && rd_addr == A_CTRL)  state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (rd_addr == A_CTRL) begin
      rd_val[BIT_DONE] = (state == ST_DONE);
      rd_val[BIT_IDLE] = (state != ST_RUN);
    end else if (rd_addr == A_LEN) begin
      rd_val = data_length;
    end else if (rd_is_tap) begin
      rd_val = '1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_start    <= 1'b0;
      data_length <= '0;
      tap_wr_pend <= 1'b0;
      tap_wr_a    <= '0;
      tap_wr_d    <= '0;
      rd_busy     <= 1'b0;
      rd_s1       <= 1'b0;
      rd_first    <= 1'b0;
      rd_tap_live <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_addr     <= '0;
      rdata_q     <= '0;
    end else begin
      ap_start    <= start_wr;
      if (wr_grant && awaddr == A_LEN && state != ST_RUN) data_length <= wdata;
      tap_wr_pend <= wr_grant && wr_is_tap && (state != ST_RUN);
      if (wr_grant && wr_is_tap && state != ST_RUN) begin
        tap_wr_a <= awaddr - A_TAP;
        tap_wr_d <= wdata;
      end
      rd_s1    <= arready;
      rd_first <= rd_s1;
      if (arready) begin
        rd_busy <= 1'b1;
        rd_addr <= araddr;
      end
      // Register values are settled in the tap-access cycle; tap data is
      // forwarded on the first rvalid cycle and then frozen for the hold.
      if (rd_s1) begin
        rvalid_q    <= 1'b1;
        rd_tap_live <= rd_is_tap && (state != ST_RUN);
        rdata_q     <= rd_val;
      end else if (rd_first && rd_tap_live) begin
        rdata_q <= tap_Do;
      end
      if (rd_ret) begin
        rvalid_q <= 1'b0;
        rd_busy  <= 1'b0;
      end
    end
  end

  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (state == ST_RUN) begin
      tap_EN = eng_tap_en;
      tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
    end else if (tap_wr_pend) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = tap_wr_a;
      tap_Di = tap_wr_d;
    end else if (rd_s1 && rd_is_tap) begin
      tap_EN = 1'b1;
      tap_A  = rd_addr - A_TAP;
    end
  end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have parameters pADDR_WIDTH, default 12, AXI-Lite/BRAM byte address width.
REQ-002 SHALL have parameters pDATA_WIDTH, default 32, data width; and Tape_Num, default 11, tap count.
REQ-003 SHALL use one clock and an asynchronous active-low reset: axis_clk in 1 clock; axis_rst_n in 1 reset.
REQ-004 SHALL provide these AXI-Lite ports: awvalid in 1; awready out 1; awaddr in pADDR_WIDTH; wvalid in 1; wready out 1; wdata in pDATA_WIDTH.
REQ-005 SHALL provide these AXI-Lite read ports: arvalid in 1; arready out 1; araddr in pADDR_WIDTH; rvalid out 1; rready in 1; rdata out pDATA_WIDTH.
REQ-006 SHALL provide these tap RAM ports: tap_WE out 4; tap_EN out 1; tap_Di out pDATA_WIDTH; tap_A out pADDR_WIDTH (byte address); tap_Do in pDATA_WIDTH (1-cycle read latency).
REQ-007 SHALL provide these engine ports: ap_start out 1, one-cycle start pulse; data_length out pDATA_WIDTH; eng_tap_en in 1; eng_tap_idx in 4; eng_done in 1, one-cycle completion pulse.

Function
REQ-008 SHALL use this register map: 0x00 ap_ctrl (bit0 start W, bit1 ap_done RO, bit2 ap_idle RO); 0x10 data_length RW; 0x20+4*i tap i, i=0..Tape_Num-1; all other addresses unmapped.
REQ-009 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-010 SHALL take IDLE or DONE -> RUN on an accepted write to 0x00 with wdata[0]=1; ap_start SHALL pulse high on the following cycle only, and ap_done SHALL clear on entry to RUN.
REQ-011 SHALL take RUN -> DONE on eng_done=1; writes to 0x00 in RUN SHALL be ignored.
REQ-012 SHALL take DONE -> IDLE on the rdata-return cycle of a read of 0x00; that read SHALL return ap_done=1, and later reads SHALL return 0.
REQ-013 SHALL set ap_idle=1 in IDLE and DONE, 0 in RUN; ap_done=1 only in DONE.
REQ-014 SHALL grant a write (awready=wready=1 for one cycle) only when awvalid and wvalid are both high; no grant SHALL occur when either is low.
REQ-015 SHALL give a tap write the cycle after its grant: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata.
REQ-016 SHALL pulse arready for one cycle when arvalid=1, no read is outstanding and no write is granted that cycle; write wins a same-cycle conflict.
REQ-017 SHALL assert rvalid exactly 2 cycles after the arready cycle for every address, and hold it with rdata stable until rready=1; only one read SHALL be outstanding.
REQ-018 SHALL drive the tap read as tap_EN=1, tap_WE=0, tap_A=araddr-0x20 in the cycle after arready, and SHALL register rdata from tap_Do.
REQ-019 SHALL give the engine exclusive use of the tap port in RUN: tap_EN=eng_tap_en, tap_WE=0, tap_A=eng_tap_idx*4.
REQ-020 SHALL accept and discard tap writes in RUN; tap reads in RUN SHALL return 0xFFFFFFFF.
REQ-021 SHALL update data_length only from writes in IDLE/DONE; writes in RUN SHALL be ignored. A read of 0x10 SHALL return data_length.
REQ-022 SHALL accept and discard unmapped writes; unmapped reads SHALL return 0.
REQ-023 SHALL treat eng_done outside RUN as ignored.

Reset
REQ-024 SHALL, on axis_rst_n=0, set FSM=IDLE, data_length=0, ap_start=0, awready=wready=arready=rvalid=0, rdata=0, tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0.
REQ-025 SHALL drop any outstanding read on a mid-operation reset (no rvalid after release); the engine grant SHALL be revoked immediately.

Structure
REQ-026 SHALL place register offsets (0x00, 0x10, 0x20), the ap_ctrl bit positions and the FSM state enum in a shared package fir_pkg.
REQ-027 SHALL consist of a single module with no sub-modules; tap port muxing SHALL be inline.

Verification
REQ-028 Verification SHALL cover: write tap 0x24=0x5 then read 0x24 -> rdata=0x5, rvalid 2 cycles after arready.
REQ-029 Verification SHALL cover: write 0x10=600, then 0x00=1 -> ap_start pulse 1 cycle, data_length=600, read 0x00 = 0x0 (idle=0).
REQ-030 Verification SHALL cover: in RUN, eng_tap_en=1, idx=3 -> tap_A=0x0C, WE=0; an AXI write to 0x20 leaves tap 0 unchanged; a read of 0x20 returns 0xFFFFFFFF.
REQ-031 Verification SHALL cover: eng_done pulse -> read 0x00 returns 0x6; next read returns 0x4.
REQ-032 Verification SHALL cover: same-cycle write 0x28 and read 0x2C -> write granted first, arready a cycle later, both correct.
REQ-033 Verification SHALL cover: reset asserted in RUN with a read pending -> IDLE, no rvalid, read 0x00 = 0x4 after release.
